// File: rtl/ravenoc_pkg.sv
// Shared types and helpers for the packet framer.
package ravenoc_pkg;

  localparam int unsigned FlitWidthDef     = 34;
  localparam int unsigned FlitDataWidthDef = 32;
  localparam int unsigned NumVirtChnDef    = 3;

  // Two-bit flit type carried in the flit MSBs; 2'b11 is decoded as BODY.
  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BODY = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_BUSY = 1'b1
  } rx_state_e;

  // VC index width, never narrower than one bit.
  function automatic int unsigned vc_width(input int unsigned num_vc);
    return (num_vc <= 1) ? 1 : $clog2(num_vc);
  endfunction

  localparam int unsigned VcWidthDef = vc_width(NumVirtChnDef);

  typedef struct packed {
    logic [FlitWidthDef-1:0] fdata;
    logic [VcWidthDef-1:0]   vc_id;
  } s_flit_req_t;

endpackage

// File: rtl/pkt_framer_skid.sv
// Two-entry valid/ready buffer with registered ready and registered output.
module pkt_framer_skid #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic [1:0]       cnt_q, cnt_d;
  logic [Width-1:0] out_q, out_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             push, pop;

  assign push = in_valid_i & rdy_q;
  assign pop  = vld_q & out_ready_i;

  // Occupancy update: slot out_q always holds the oldest entry, skid_q the second.
  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    skid_d = skid_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          out_d = in_data_i;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          out_d = in_data_i;
        end else if (push) begin
          skid_d = in_data_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          out_d = skid_q;
          cnt_d = 2'd1;
        end
      end
    endcase
    rdy_d = (cnt_d != 2'd2);
    vld_d = (cnt_d != 2'd0);
  end

  // Buffer state registers; reset drops any buffered entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      out_q  <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = vld_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/pkt_framer.sv
// Frames AXI beats into HEAD/BODY/TAIL flits and tracks packet boundaries on receive.
module pkt_framer
  import ravenoc_pkg::*;
#(
  parameter int unsigned FlitWidth     = 34,
  parameter int unsigned FlitDataWidth = 32,
  parameter int unsigned NumVirtChn    = 3,
  parameter int unsigned PktWidth      = 8,
  parameter int unsigned PktSzMsb      = 31,
  parameter int unsigned AutoAddPktSz  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tx_valid_i,
  output logic                              tx_ready_o,
  input  logic [FlitDataWidth-1:0]          tx_data_i,
  input  logic [vc_width(NumVirtChn)-1:0]   tx_vc_i,
  input  logic [PktWidth-1:0]               tx_pkt_sz_i,
  output logic                              noc_valid_o,
  input  logic                              noc_ready_i,
  output logic [FlitWidth-1:0]              noc_fdata_o,
  output logic [vc_width(NumVirtChn)-1:0]   noc_vc_o,
  input  logic                              noc_in_valid_i,
  output logic                              noc_in_ready_o,
  input  logic [FlitWidth-1:0]              noc_in_fdata_i,
  input  logic [vc_width(NumVirtChn)-1:0]   noc_in_vc_i,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  output logic [FlitDataWidth-1:0]          rx_data_o,
  output logic [vc_width(NumVirtChn)-1:0]   rx_vc_o,
  output logic                              rx_last_o,
  output logic                              rx_err_o
);

  localparam int unsigned VcWidth   = vc_width(NumVirtChn);
  localparam int unsigned SkidWidth = FlitWidth + VcWidth;

  // ---------------- TX framing ----------------
  logic                     tx_fire;
  logic [NumVirtChn-1:0]    tx_body_v, tx_tail_v;
  flit_type_t               tx_type_c;
  logic [FlitDataWidth-1:0] tx_payload_c;
  logic [FlitWidth-1:0]     tx_flit_c;
  logic [SkidWidth-1:0]     skid_out;

  assign tx_fire = tx_valid_i & tx_ready_o;

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_tx
    tx_state_e           st_q, st_d;
    logic [PktWidth-1:0] rem_q, rem_d;
    logic                sel;

    assign sel = tx_fire && (tx_vc_i == VcWidth'(v));

    // Per-VC framing FSM: a HEAD opens a packet of rem flits, the last one is TAIL.
    always_comb begin
      st_d  = st_q;
      rem_d = rem_q;
      case (st_q)
        TX_IDLE: begin
          if (sel && (tx_pkt_sz_i != '0)) begin
            st_d  = TX_BODY;
            rem_d = tx_pkt_sz_i;
          end
        end
        TX_BODY: begin
          if (sel) begin
            rem_d = rem_q - PktWidth'(1);
            if (rem_q == PktWidth'(1)) st_d = TX_IDLE;
          end
        end
        default: st_d = TX_IDLE;
      endcase
    end

    // Per-VC framing state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q  <= TX_IDLE;
        rem_q <= '0;
      end else begin
        st_q  <= st_d;
        rem_q <= rem_d;
      end
    end

    assign tx_body_v[v] = sel && (st_q == TX_BODY);
    assign tx_tail_v[v] = sel && (st_q == TX_BODY) && (rem_q == PktWidth'(1));
  end

  // Flit type and head size insertion for the beat being accepted.
  always_comb begin
    tx_payload_c = tx_data_i;
    tx_type_c    = HEAD_FLIT;
    if (|tx_tail_v) begin
      tx_type_c = TAIL_FLIT;
    end else if (|tx_body_v) begin
      tx_type_c = BODY_FLIT;
    end else if (AutoAddPktSz != 0) begin
      tx_payload_c[PktSzMsb -: PktWidth] = tx_pkt_sz_i;
    end
  end

  assign tx_flit_c = {tx_type_c, tx_payload_c};

  pkt_framer_skid #(
    .Width(SkidWidth)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (tx_valid_i),
    .in_ready_o (tx_ready_o),
    .in_data_i  ({tx_vc_i, tx_flit_c}),
    .out_valid_o(noc_valid_o),
    .out_ready_i(noc_ready_i),
    .out_data_o (skid_out)
  );

  assign noc_vc_o    = skid_out[SkidWidth-1 -: VcWidth];
  assign noc_fdata_o = skid_out[FlitWidth-1:0];

  // ---------------- RX tracking ----------------
  logic                  rx_fire;
  logic [1:0]            rx_type_raw;
  logic                  rx_is_head, rx_is_tail;
  logic [PktWidth-1:0]   rx_sz;
  logic [NumVirtChn-1:0] rx_last_v, rx_err_v;
  logic                  rx_err_q, rx_err_d;

  assign rx_fire     = noc_in_valid_i & rx_ready_i;
  assign rx_type_raw = noc_in_fdata_i[FlitWidth-1 -: 2];
  assign rx_is_head  = (rx_type_raw == HEAD_FLIT);
  assign rx_is_tail  = (rx_type_raw == TAIL_FLIT);
  assign rx_sz       = noc_in_fdata_i[PktSzMsb -: PktWidth];

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_rx
    rx_state_e           st_q, st_d;
    logic [PktWidth-1:0] rrem_q, rrem_d;
    logic                hit, fire, last_c, err_c;

    assign hit  = (noc_in_vc_i == VcWidth'(v));
    assign fire = rx_fire & hit;

    // Per-VC receive tracker: counts flits after the head and flags violations.
    always_comb begin
      st_d   = st_q;
      rrem_d = rrem_q;
      last_c = 1'b0;
      err_c  = 1'b0;
      if (rx_is_head) begin
        last_c = (rx_sz == '0);
        err_c  = (st_q == RX_BUSY);
        if (fire) begin
          rrem_d = rx_sz;
          st_d   = (rx_sz == '0) ? RX_IDLE : RX_BUSY;
        end
      end else begin
        case (st_q)
          RX_BUSY: begin
            last_c = (rrem_q == PktWidth'(1));
            err_c  = last_c ? !rx_is_tail : rx_is_tail;
            if (fire) begin
              rrem_d = rrem_q - PktWidth'(1);
              if (last_c || rx_is_tail) st_d = RX_IDLE;
            end
          end
          default: err_c = 1'b1;
        endcase
      end
    end

    // Per-VC tracker state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= RX_IDLE;
        rrem_q <= '0;
      end else begin
        st_q   <= st_d;
        rrem_q <= rrem_d;
      end
    end

    assign rx_last_v[v] = hit & last_c;
    assign rx_err_v[v]  = fire & err_c;
  end

  assign rx_err_d = |rx_err_v;

  // Error pulse register, one cycle after the offending handshake.
  always_ff @(posedge clk) begin
    if (rst) rx_err_q <= 1'b0;
    else     rx_err_q <= rx_err_d;
  end

  assign noc_in_ready_o = rx_ready_i;
  assign rx_valid_o     = noc_in_valid_i;
  assign rx_data_o      = noc_in_fdata_i[FlitDataWidth-1:0];
  assign rx_vc_o        = noc_in_vc_i;
  assign rx_last_o      = |rx_last_v;
  assign rx_err_o       = rx_err_q;

endmodule
